// File: rtl/player_id_if.sv
// Bundles the burst-request, ROM read and word-stream signals of the player-ID reader.
// The slave modport is the reader's view; master is the surrounding game logic, ROM and consumer.
interface player_id_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_index;
  logic [ADDR_W:0]   req_count;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_data;
  logic              id_last;
  logic              busy;

  modport master (
    output req_valid, req_index, req_count, rom_q, id_ready,
    input  req_ready, rom_addr, id_valid, id_data, id_last, busy
  );

  modport slave (
    input  req_valid, req_index, req_count, rom_q, id_ready,
    output req_ready, rom_addr, id_valid, id_data, id_last, busy
  );
endinterface

// File: rtl/player_id_reader.sv
// Burst reader for the player-ID ROM: issues one address per cycle under FIFO credit,
// tracks the fixed ROM latency with a tag pipeline and streams words out through a small FIFO.
module player_id_reader #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  player_id_if.slave bus
);

  localparam int                PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0]   FULL_BURST = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [PTR_W-1:0]  PTR_MAX    = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  // Stage 0 tracks the address currently on rom_addr; stage ROM_LATENCY lines up with rom_q.
  logic [ROM_LATENCY:0] tag_valid_q, tag_valid_d;
  logic [ROM_LATENCY:0] tag_last_q, tag_last_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic                fifo_last [FIFO_DEPTH];

  logic                push, pop, issue, issue_last;
  logic [ADDR_W-1:0]   issue_addr;
  logic [ADDR_W:0]     burst_len;
  int                  outstanding;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign push = tag_valid_q[ROM_LATENCY];
  assign pop  = (count_q != '0) && bus.id_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    remaining_d = remaining_q;
    rom_addr_d  = rom_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    tag_valid_d = {tag_valid_q[ROM_LATENCY-1:0], 1'b0};
    tag_last_d  = {tag_last_q[ROM_LATENCY-1:0], 1'b0};
    issue       = 1'b0;
    issue_last  = 1'b0;
    issue_addr  = addr_cnt_q;
    burst_len   = (bus.req_count == '0) ? FULL_BURST : bus.req_count;

    // Words already owned by the FIFO or in flight, after this cycle's pop; a pop frees its slot
    // for an issue at the same edge.
    outstanding = int'(count_q) + $countones(tag_valid_q) - int'(pop);

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          issue       = 1'b1;
          issue_addr  = bus.req_index;
          issue_last  = (burst_len == 1);
          addr_cnt_d  = bus.req_index + 1'b1;
          remaining_d = burst_len - 1'b1;
          state_d     = (burst_len == 1) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (outstanding < FIFO_DEPTH) begin
          issue       = 1'b1;
          issue_last  = (remaining_q == 1);
          addr_cnt_d  = addr_cnt_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == 1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outstanding == 0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      rom_addr_d     = issue_addr;
      tag_valid_d[0] = 1'b1;
      tag_last_d[0]  = issue_last;
    end

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      addr_cnt_q  <= '0;
      remaining_q <= '0;
      rom_addr_q  <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      tag_valid_q <= '0;
      tag_last_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      remaining_q <= remaining_d;
      rom_addr_q  <= rom_addr_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      tag_valid_q <= tag_valid_d;
      tag_last_q  <= tag_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= bus.rom_q;
      fifo_last[wr_ptr_q] <= tag_last_q[ROM_LATENCY];
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.id_valid  = (count_q != '0);
  assign bus.id_data   = bus.id_valid ? fifo_data[rd_ptr_q] : '0;
  assign bus.id_last   = bus.id_valid ? fifo_last[rd_ptr_q] : 1'b0;

endmodule
